// File: rtl/touch_pkg.sv
// Shared types and frame geometry for the touch-screen controller reader.
package touch_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_SHIFT, ST_GAP} state_t;

  localparam int CMD_BITS   = 8;
  localparam int DATA_BITS  = 12;
  localparam int FRAME_BITS = 24;
  localparam int DATA_FIRST = 9;
  localparam int DATA_LAST  = 20;
endpackage

// File: rtl/tp_sync.sv
// Two-flop synchronizer bringing the controller's serial data into clk.
module tp_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/touch_adc_reader.sv
// Runs one 24-clock serial frame with a touch-screen ADC controller per start request.
// state | meaning
// IDLE  | waiting for start, counters held at zero
// SETUP | chip select asserted, first command bit on TP_DIN, one half period
// SHIFT | 24 TP_DCLK periods: command out, 12 result bits in
// GAP   | chip select released for two half periods, done on the last clk
module touch_adc_reader
  import touch_pkg::*;
#(
  parameter int HALF_PER = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [CMD_BITS-1:0]  cmd,
  output logic                 busy,
  output logic                 done,
  output logic [DATA_BITS-1:0] data,
  output logic                 TP_CS,
  output logic                 TP_DCLK,
  output logic                 TP_DIN,
  input  logic                 TP_DOUT
);
  localparam int CW = $clog2(2 * HALF_PER);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF_PER - 1);
  localparam logic [CW-1:0] GAP_M1  = CW'(2 * HALF_PER - 1);
  localparam logic [CW-1:0] H_ONE   = CW'(1);
  localparam logic [4:0]    K_FIRST = 5'(DATA_FIRST);
  localparam logic [4:0]    K_LAST  = 5'(DATA_LAST);
  localparam logic [4:0]    K_END   = 5'(FRAME_BITS - 1);
  localparam logic [4:0]    K_ONE   = 5'd1;

  state_t                 state, state_n;
  logic [CW-1:0]          hcnt, hcnt_n;
  logic [4:0]             kcnt, kcnt_n;
  logic [CMD_BITS-2:0]    cmd_q, cmd_n;
  logic [DATA_BITS-1:0]   shreg, sh_n, data_n;
  logic                   busy_n, done_n, cs_n, dclk_n, din_n;
  logic                   dout_s;

  tp_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (TP_DOUT),
    .q     (dout_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      hcnt    <= '0;
      kcnt    <= '0;
      cmd_q   <= '0;
      shreg   <= '0;
      data    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      TP_CS   <= 1'b1;
      TP_DCLK <= 1'b0;
      TP_DIN  <= 1'b0;
    end else begin
      state   <= state_n;
      hcnt    <= hcnt_n;
      kcnt    <= kcnt_n;
      cmd_q   <= cmd_n;
      shreg   <= sh_n;
      data    <= data_n;
      busy    <= busy_n;
      done    <= done_n;
      TP_CS   <= cs_n;
      TP_DCLK <= dclk_n;
      TP_DIN  <= din_n;
    end
  end

  // TP_DCLK itself marks the high/low phase of the current bit period.
  always_comb begin
    state_n = state;
    hcnt_n  = hcnt;
    kcnt_n  = kcnt;
    cmd_n   = cmd_q;
    sh_n    = shreg;
    data_n  = data;
    busy_n  = busy;
    done_n  = 1'b0;
    cs_n    = TP_CS;
    dclk_n  = TP_DCLK;
    din_n   = TP_DIN;
    case (state)
      ST_IDLE: begin
        hcnt_n = '0;
        kcnt_n = '0;
        if (start) begin
          state_n = ST_SETUP;
          hcnt_n  = HALF_M1;
          cmd_n   = cmd[CMD_BITS-2:0];
          busy_n  = 1'b1;
          cs_n    = 1'b0;
          din_n   = cmd[CMD_BITS-1];
        end
      end
      ST_SETUP: begin
        if (hcnt == '0) begin
          state_n = ST_SHIFT;
          hcnt_n  = HALF_M1;
          dclk_n  = 1'b1;
        end else begin
          hcnt_n = hcnt - H_ONE;
        end
      end
      ST_SHIFT: begin
        if (hcnt != '0) begin
          hcnt_n = hcnt - H_ONE;
        end else begin
          hcnt_n = HALF_M1;
          if (TP_DCLK) begin
            dclk_n = 1'b0;
            // remaining command bits drain out MSB first; zeros follow
            din_n  = cmd_q[CMD_BITS-2];
            cmd_n  = {cmd_q[CMD_BITS-3:0], 1'b0};
            if (kcnt >= K_FIRST && kcnt <= K_LAST)
              sh_n = {shreg[DATA_BITS-2:0], dout_s};
          end else if (kcnt == K_END) begin
            state_n = ST_GAP;
            hcnt_n  = GAP_M1;
            kcnt_n  = '0;
            cs_n    = 1'b1;
          end else begin
            kcnt_n = kcnt + K_ONE;
            dclk_n = 1'b1;
          end
        end
      end
      ST_GAP: begin
        din_n = 1'b0;
        // done/busy are registered, so they are set one clk ahead of the last GAP clk
        if (hcnt == H_ONE) begin
          data_n = shreg;
          done_n = 1'b1;
          busy_n = 1'b0;
        end
        if (hcnt == '0) state_n = ST_IDLE;
        else            hcnt_n  = hcnt - H_ONE;
      end
      default: state_n = ST_IDLE;
    endcase
  end
endmodule

// File: doc/touch_adc_reader.md
TOUCH_ADC_READER -- requirements
Module: touch_adc_reader

Interface
REQ-001 Parameter HALF_PER, default 64, TP_DCLK half-period in clk cycles (legal >= 2).
REQ-002 Port clk  input  1  system clock; all logic on posedge.
REQ-003 Port rst_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-004 Port start  input  1  request one conversion frame; sampled in IDLE only.
REQ-005 Port cmd  input  8  controller command byte, latched on accepted start.
REQ-006 Port busy  output  1  high from cycle after accepted start until done cycle.
REQ-007 Port done  output  1  one-clk pulse at frame end; data valid from this cycle.
REQ-008 Port data  output  12  last conversion result, held until next done.
REQ-009 Port TP_CS  output  1  controller chip select, active low.
REQ-010 Port TP_DCLK  output  1  serial clock to controller, idles low.
REQ-011 Port TP_DIN  output  1  command bits to controller, MSB first.
REQ-012 Port TP_DOUT  input  1  result bits from controller, asynchronous to clk.

Function
REQ-013 States SHALL be IDLE, SETUP, SHIFT, GAP; all outputs registered.
REQ-014 IDLE: start=1 latches cmd, next cycle SETUP with TP_CS=0, busy=1, TP_DIN=cmd[7].
REQ-015 SETUP SHALL last HALF_PER clks with TP_DCLK=0, then enter SHIFT.
REQ-016 SHIFT SHALL run 24 bit periods k=0..23; each = HALF_PER clks TP_DCLK=1 then HALF_PER clks TP_DCLK=0.
REQ-017 TP_DIN SHALL change only at TP_DCLK falling edge: after period k<7 it becomes cmd[6-k]; after period 7 and onward it is 0.
REQ-018 Synchronized TP_DOUT SHALL be sampled on the last clk of the high phase of periods k=9..20, shifted MSB first into 12-bit register.
REQ-019 After low phase of period 23: TP_CS=1, enter GAP for 2*HALF_PER clks, TP_DCLK=0, TP_DIN=0.
REQ-020 On last GAP clk: data<=shift register, done=1 for one clk, busy=0, return to IDLE.
REQ-021 Frame length start-accept to done SHALL be exactly 51*HALF_PER clks.
REQ-022 start while busy=1 SHALL be ignored, no queuing; start on the done cycle ignored, accepted the following cycle.
REQ-023 TP_DOUT SHALL pass a 2-flop synchronizer before use; sampled value within the HALF_PER window is the synchronizer output.
REQ-024 Half-period and bit counters SHALL wrap only under state control; no counter runs in IDLE.

Reset
REQ-025 rst_n=0 SHALL immediately force TP_CS=1, TP_DCLK=0, TP_DIN=0, busy=0, done=0, data=0, state=IDLE, counters=0.
REQ-026 Reset mid-frame SHALL abort without done pulse; first frame after release starts cleanly from SETUP.

Structure
REQ-027 Package touch_pkg SHALL hold state enum, CMD_BITS=8, DATA_BITS=12, FRAME_BITS=24, DATA_FIRST=9, DATA_LAST=20.
REQ-028 One sub-module tp_sync (2-flop synchronizer, async active-low reset to 0) SHALL be instantiated for TP_DOUT.

Verification (HALF_PER=4)
REQ-029 start with cmd=0x90, controller model returns 0xA5C -> TP_DIN at rising edges 1,0,0,1,0,0,0,0; data=0xA5C; done exactly 204 clks after accept.
REQ-030 Model returns 0xFFF then 0x000 on back-to-back frames -> data 0xFFF then 0x000; TP_CS high >= 8 clks between frames.
REQ-031 start pulsed at clks 10 and 100 of a frame -> single done, no second frame.
REQ-032 rst_n low at clk 50 of a frame -> TP_CS=1, TP_DCLK=0 same cycle, no done; next start produces a full correct frame.
REQ-033 start held high continuously -> frames repeat with one IDLE clk between done and next accept; TP_DCLK count per frame exactly 24.
